// File: rtl/mem_bus_responder.sv
// Memory bus responder: turns single-cycle decoder read/write requests into a
// strobed external access with wait states. Optional ACCESS timeout: MEM_TIMEOUT_EN.
module mem_bus_responder #(
    parameter int         WAIT_CYCLES = 1,
    parameter logic [7:0] TIMEOUT     = 8'd255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_stall,
    output logic        o_err,
    output logic [15:0] o_ext_addr,
    output logic [15:0] o_ext_wdata,
    output logic        o_ext_re,
    output logic        o_ext_we,
    input  logic [15:0] i_ext_rdata,
    input  logic        i_ext_rdy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic [7:0]  tcnt_q, tcnt_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        err_d   = 1'b0;
        tcnt_d  = tcnt_q;
        case (state_q)
            IDLE: begin
                if (i_mem_rd ^ i_mem_wr) begin
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                    wr_d    = i_mem_wr;
                    wcnt_d  = 4'(WAIT_CYCLES);
                    tcnt_d  = '0;
                    state_d = ACCESS;
                end else if (i_mem_rd && i_mem_wr) begin
                    err_d = 1'b1;
                end
            end
            ACCESS: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else if (i_ext_rdy) begin
                    if (!wr_q) rdata_d = i_ext_rdata;
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                // Normal completion wins over a timeout landing on the same cycle.
                if (state_d != DONE) begin
                    if (tcnt_q == TIMEOUT - 8'd1) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                        if (!wr_q) rdata_d = 16'hFFFF;
                    end else begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifndef MEM_TIMEOUT_EN
    logic unused_timeout;
    assign unused_timeout = ^{TIMEOUT, tcnt_q};
`endif

    always_comb begin
        o_stall  = (state_q == ACCESS) || ((state_q == IDLE) && (i_mem_rd ^ i_mem_wr));
        o_ext_re = (state_q == ACCESS) && !wr_q;
        o_ext_we = (state_q == ACCESS) && wr_q;
    end

    assign o_rdata     = rdata_q;
    assign o_err       = err_q;
    assign o_ext_addr  = addr_q;
    assign o_ext_wdata = wdata_q;
endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, range 0..15: minimum number of strobe cycles before the first i_ext_rdy sample.
REQ-002 Parameter TIMEOUT, default 255, 8-bit: abort limit in ACCESS cycles; used only when MEM_TIMEOUT_EN is defined.
REQ-003 One clock; reset is synchronous and active-low: i_clk and i_rst_n.
REQ-004 i_clk  in  1  sole clock, rising edge.
REQ-005 i_rst_n  in  1  synchronous active-low reset.
REQ-006 i_mem_rd  in  1  read request from the instruction decoder.
REQ-007 i_mem_wr  in  1  write request from the instruction decoder.
REQ-008 i_addr  in  16  address, taken from the ADDR register.
REQ-009 i_wdata  in  16  write data, taken from the ALU result bus.
REQ-010 o_rdata  out  16  read data, driven onto the bus as source MEM.
REQ-011 o_stall  out  1  holds the decoder FSM in its current state while high.
REQ-012 o_err  out  1  one-cycle error pulse.
REQ-013 o_ext_addr / o_ext_wdata  out  16 each  external memory address and write data.
REQ-014 o_ext_re / o_ext_we  out  1 each  external read and write strobes.
REQ-015 i_ext_rdata  in  16  external read data.
REQ-016 i_ext_rdy  in  1  external ready; sampled only in ACCESS.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-018 IDLE behaviour SHALL depend on the requests:
- exactly one of i_mem_rd / i_mem_wr high: latch i_addr, i_wdata and the direction; load the wait counter with WAIT_CYCLES; go to ACCESS.
- both requests low: stay in IDLE.
REQ-019 o_stall SHALL be combinational and high in the following cases:
- the IDLE cycle in which a valid request is present;
- every ACCESS cycle.
o_stall SHALL be low in all other cycles.
REQ-020 In ACCESS, o_ext_addr and o_ext_wdata SHALL drive the latched values, and exactly one strobe SHALL be high, matching the latched direction.
REQ-021 In ACCESS, the wait counter SHALL decrement each cycle while nonzero; i_ext_rdy SHALL be ignored while the counter is nonzero.
REQ-022 When the counter is 0 and i_ext_rdy=1: capture i_ext_rdata into o_rdata (reads only) and go to DONE.
REQ-023 DONE SHALL last exactly one cycle:
- strobes low, o_stall low;
- the still-asserted request for the completing access is ignored;
- next state is IDLE.
REQ-024 o_rdata SHALL hold its value until the next read completes; writes SHALL leave o_rdata unchanged.
REQ-025 Latency: request at cycle t with i_ext_rdy held high gives completion as follows:
- ACCESS for WAIT_CYCLES+1 cycles;
- DONE at cycle t+WAIT_CYCLES+2;
- o_stall high from cycle t through t+WAIT_CYCLES+1.
REQ-026 i_mem_rd=i_mem_wr=1 in IDLE SHALL produce the following: o_err=1 for one cycle, no access, o_stall=0, and the FSM stays in IDLE.
REQ-027 Changes on i_addr, i_wdata or the request inputs during ACCESS SHALL have no effect.
REQ-028 When both strobes are low, o_ext_addr and o_ext_wdata SHALL hold their last values.

Reset
REQ-029 When i_rst_n=0 at a rising edge, the block SHALL reset as follows:
- state=IDLE, counter=0, o_rdata=16'h0000;
- o_ext_addr=0, o_ext_wdata=0;
- o_ext_re=0, o_ext_we=0, o_err=0.
REQ-030 A reset during ACCESS SHALL drop the strobes at that edge; the aborted access SHALL neither update o_rdata nor pulse o_err.
REQ-031 o_stall SHALL be 0 in the cycle following reset, unless a new request is present in that cycle.

Configuration
REQ-032 The feature controlled by macro MEM_TIMEOUT_EN SHALL be the ACCESS timeout.
REQ-033 With MEM_TIMEOUT_EN defined, the timeout SHALL behave as follows:
- an 8-bit counter counts ACCESS cycles;
- reaching TIMEOUT without completion forces DONE with o_err=1 for one cycle;
- on a timed-out read, o_rdata=16'hFFFF.
REQ-034 Without MEM_TIMEOUT_EN, ACCESS SHALL wait indefinitely for i_ext_rdy, and o_err SHALL arise only from REQ-026.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- Read, WAIT_CYCLES=1, rdy=1, addr=16'h1234, ext_rdata=16'hBEEF at cycle t -> ACCESS t+1..t+2; DONE t+3; o_stall high t..t+2; o_rdata=16'hBEEF from t+3.
- Write, WAIT_CYCLES=0, rdy=1, addr=16'h00FF, wdata=16'hA5A5 -> o_ext_we high for one cycle with those values; o_rdata unchanged.
- Read with rdy low for 5 cycles after the wait expires -> o_stall held high; completes in the cycle rdy rises; no o_err (macro off).
- i_mem_rd=i_mem_wr=1 in IDLE -> single o_err pulse; strobes stay low; o_stall=0.
- i_rst_n=0 during ACCESS of a read -> strobes low at that edge; state IDLE; o_rdata=16'h0000.
- MEM_TIMEOUT_EN defined, TIMEOUT=4, rdy stuck low on a read -> DONE after 4 ACCESS cycles; o_err pulse; o_rdata=16'hFFFF.
